// File: rtl/sa_pkg.sv
// Shared definitions for the systolic array: operand/accumulator widths, the
// operand feeder state encoding and the flush-length helper.
package sa_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned ACC_W = 19;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StFlush,
    StTail,
    StDone
  } feeder_state_e;

  // Zero slices needed to push the last real slice through both skew and array.
  function automatic int unsigned flush_len(input int unsigned n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/sa_skew_lane.sv
// One skew lane: a DEPTH-stage operand delay chain that shifts only on advance
// and can be synchronously zeroed.
module sa_skew_lane #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned DW    = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          advance,
  input  logic          clear,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] stage_q [DEPTH];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int s = 0; s < int'(DEPTH); s++) begin
        stage_q[s] <= '0;
      end
    end else if (clear) begin
      for (int s = 0; s < int'(DEPTH); s++) begin
        stage_q[s] <= '0;
      end
    end else if (advance) begin
      stage_q[0] <= d;
      for (int s = 1; s < int'(DEPTH); s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/sa_operand_feeder.sv
// Systolic array operand feeder: accepts K-slices, skews lane i by i cycles and
// drives PE_EN/PE_CLR. Optional stall counter: define SA_FEEDER_STALL_CNT_EN.
module sa_operand_feeder #(
  parameter int unsigned N     = 4,
  parameter int unsigned K_MAX = 8,
  parameter int unsigned DW    = sa_pkg::DW,
  localparam int unsigned KW   = $clog2(K_MAX + 1)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_a,
  input  logic [N*DW-1:0] in_b,
  output logic [N*DW-1:0] A_row,
  output logic [N*DW-1:0] B_col,
  output logic            PE_EN,
  output logic            PE_CLR,
  output logic            busy,
  output logic            done,
  output logic [15:0]     stall_cycles
);

  import sa_pkg::*;

  localparam int unsigned FlushLen = flush_len(N);
  localparam int unsigned CW       = $clog2(K_MAX + FlushLen + 1);

  feeder_state_e   state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pe_en_q;
  logic            feeding, flushing, clr, advance;
  logic [N*DW-1:0] a_d, b_d;

  assign feeding  = (state_q == StFeed);
  assign flushing = (state_q == StFlush);
  assign clr      = (state_q == StClear);
  assign advance  = (feeding && in_valid) || flushing;

  // Flush injects zeros so the tail of each lane drains without extra gating.
  assign a_d = feeding ? in_a : '0;
  assign b_d = feeding ? in_b : '0;

  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClear;
          k_len_d = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
        end
      end
      StClear: begin
        cnt_d   = '0;
        state_d = (k_len_q == '0) ? StFlush : StFeed;
      end
      StFeed: begin
        if (in_valid) begin
          if (cnt_q == CW'(k_len_q) - CW'(1)) begin
            cnt_d   = '0;
            state_d = StFlush;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      StFlush: begin
        if (cnt_q == CW'(FlushLen - 1)) begin
          cnt_d   = '0;
          state_d = StTail;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StTail:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      k_len_q <= '0;
      cnt_q   <= '0;
      pe_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      cnt_q   <= cnt_d;
      pe_en_q <= advance;
    end
  end

  assign in_ready = feeding;
  assign PE_EN    = pe_en_q;
  assign PE_CLR   = clr;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

  for (genvar i = 0; i < N; i++) begin : g_lane
    sa_skew_lane #(
      .DEPTH (i + 1),
      .DW    (DW)
    ) u_a_lane (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .advance (advance),
      .clear   (clr),
      .d       (a_d[i*DW +: DW]),
      .q       (A_row[i*DW +: DW])
    );

    sa_skew_lane #(
      .DEPTH (i + 1),
      .DW    (DW)
    ) u_b_lane (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .advance (advance),
      .clear   (clr),
      .d       (b_d[i*DW +: DW]),
      .q       (B_col[i*DW +: DW])
    );
  end

`ifdef SA_FEEDER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (clr) begin
      stall_d = '0;
    end else if (feeding && !in_valid && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_sa_operand_feeder.sv
// Self-checking bench for sa_operand_feeder: behavioural PE array, table of
// directed jobs, a mid-job reset and randomized jobs with stalls.
module tb_sa_operand_feeder;

  localparam int N     = 4;
  localparam int K_MAX = 8;
  localparam int DW    = 8;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int NS    = K_MAX + 4;

`ifdef SA_FEEDER_STALL_CNT_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic            CLK;
  logic            RST_N;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_a, in_b, A_row, B_col;
  logic            PE_EN, PE_CLR, busy, done;
  logic [15:0]     stall_cycles;

  sa_operand_feeder #(
    .N     (N),
    .K_MAX (K_MAX),
    .DW    (DW)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .start        (start),
    .k_len        (k_len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .A_row        (A_row),
    .B_col        (B_col),
    .PE_EN        (PE_EN),
    .PE_CLR       (PE_CLR),
    .busy         (busy),
    .done         (done),
    .stall_cycles (stall_cycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  int     sa [NS][N];
  int     sb [NS][N];
  int     gap [NS];
  longint acc [N][N];
  int     ar [N][N];
  int     br [N][N];
  bit     en_hist [200];

  typedef struct {
    int     k;
    int     pat;
    int     gap_slice;
    int     gap_len;
    int     exp_done;
    longint exp_c00;
    longint exp_c33;
    longint exp_c02;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Array PE: registers A/B on EN and adds the previously registered product.
  task automatic pe_step();
    int an [N][N];
    int bn [N][N];
    if (PE_EN) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc[i][j] = (acc[i][j] + longint'(ar[i][j]) * br[i][j]) % (64'd1 << 19);
          if (j == 0) an[i][j] = int'(A_row[i*DW +: DW]);
          else        an[i][j] = ar[i][j-1];
          if (i == 0) bn[i][j] = int'(B_col[j*DW +: DW]);
          else        bn[i][j] = br[i-1][j];
        end
      end
      ar = an;
      br = bn;
    end else if (PE_CLR) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc[i][j] = 0;
          ar[i][j]  = 0;
          br[i][j]  = 0;
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_A_row"}, longint'(A_row), 0);
    chk({tag, "_B_col"}, longint'(B_col), 0);
    chk({tag, "_PE_EN"}, longint'(PE_EN), 0);
    chk({tag, "_PE_CLR"}, longint'(PE_CLR), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_in_ready"}, longint'(in_ready), 0);
    chk({tag, "_stall"}, longint'(stall_cycles), 0);
  endtask

  task automatic fill(input int pat);
    for (int s = 0; s < NS; s++) begin
      gap[s] = 0;
      for (int i = 0; i < N; i++) begin
        case (pat)
          0:       begin sa[s][i] = i + 1 + s; sb[s][i] = i + 5 + s; end
          1:       begin sa[s][i] = 255;       sb[s][i] = 255;       end
          default: begin
            sa[s][i] = int'($urandom_range(0, 255));
            sb[s][i] = int'($urandom_range(0, 255));
          end
        endcase
      end
    end
  endtask

  // Called at a falling edge; that cycle becomes cycle 0 of the job.
  task automatic run_job(input string tag, input int k_in, input int abort_at,
                         output int done_cyc);
    int keff, stalls, s, grem, ndone, en_n, rdy_n;
    int clr_err, busy_err, edge_err, c_err, idx, ea, eb;
    longint stall_done, stall_hold, ec;
    keff = (k_in > K_MAX) ? K_MAX : k_in;
    stalls = 0;
    for (int q = 0; q < keff; q++) stalls += gap[q];
    s = 0; grem = gap[0]; ndone = 0; done_cyc = -1; en_n = 0; rdy_n = 0;
    clr_err = 0; busy_err = 0; edge_err = 0; c_err = 0;
    stall_done = -1; stall_hold = -1;
    for (int t = 0; t < 200; t++) en_hist[t] = 1'b0;

    for (int t = 0; t < 200; t++) begin
      if (t > 0) begin
        if (done) begin
          ndone++;
          if (done_cyc < 0) done_cyc = t;
        end
        if (PE_CLR != (t == 1)) clr_err++;
        if (busy != ((done_cyc < 0) || (t == done_cyc))) busy_err++;
        if (t == 2) chk({tag, "_stall_clr"}, longint'(stall_cycles), 0);
        if (t == done_cyc) stall_done = longint'(stall_cycles);
        if (done_cyc >= 0 && t == done_cyc + 3) stall_hold = longint'(stall_cycles);
        if (in_ready) rdy_n++;
        en_hist[t] = PE_EN;
        if (PE_EN) begin
          // n-th enabled cycle shows slice n-i on lane i, zeros outside the job.
          for (int i = 0; i < N; i++) begin
            idx = en_n - i;
            ea = (idx >= 0 && idx < keff) ? sa[idx][i] : 0;
            eb = (idx >= 0 && idx < keff) ? sb[idx][i] : 0;
            if (int'(A_row[i*DW +: DW]) != ea) edge_err++;
            if (int'(B_col[i*DW +: DW]) != eb) edge_err++;
          end
          en_n++;
        end
      end
      if (done_cyc >= 0 && t >= done_cyc + 4) break;
      if (t == abort_at) begin
        RST_N = 1'b0;
        #1;
        check_zero({tag, "_rst"});
        start = 1'b0;
        in_valid = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        return;
      end
      pe_step();
      start = (t == 0) || (t == 4);
      k_len = (t == 0) ? KW'(k_in) : KW'($urandom_range(0, 15));
      if (grem > 0 || s >= NS) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
          in_a[i*DW +: DW] = DW'(sa[s][i]);
          in_b[i*DW +: DW] = DW'(sb[s][i]);
        end
      end
      if (in_ready) begin
        if (grem > 0) begin
          grem--;
        end else if (in_valid) begin
          s++;
          grem = (s < NS) ? gap[s] : 0;
        end
      end
      @(negedge CLK);
    end
    in_valid = 1'b0;
    start = 1'b0;

    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ec = 0;
        for (int q = 0; q < keff; q++) ec += longint'(sa[q][i]) * sb[q][j];
        if (acc[i][j] != ec) c_err++;
      end
    end
    chk({tag, "_done_cycle"}, done_cyc, keff + 2 * N + 2 + stalls);
    chk({tag, "_done_pulses"}, ndone, 1);
    chk({tag, "_pe_clr_sched"}, clr_err, 0);
    chk({tag, "_busy_sched"}, busy_err, 0);
    chk({tag, "_pe_en_count"}, en_n, keff + 2 * N - 1);
    chk({tag, "_ready_cycles"}, rdy_n, keff + stalls);
    chk({tag, "_edge_data"}, edge_err, 0);
    chk({tag, "_c_matrix"}, c_err, 0);
    chk({tag, "_stall_at_done"}, stall_done, StallEn ? stalls : 0);
    chk({tag, "_stall_hold"}, stall_hold, StallEn ? stalls : 0);
  endtask

  initial begin
    int d;
    RST_N = 1'b0; start = 1'b0; in_valid = 1'b0; k_len = '0; in_a = '0; in_b = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc[i][j] = 0; ar[i][j] = 0; br[i][j] = 0;
      end
    end

    vecs[0] = '{k: 1,  pat: 0, gap_slice: 0, gap_len: 0, exp_done: 11,
                exp_c00: 5, exp_c33: 32, exp_c02: 7};
    vecs[1] = '{k: 8,  pat: 1, gap_slice: 0, gap_len: 0, exp_done: 18,
                exp_c00: 520200, exp_c33: 520200, exp_c02: 520200};
    vecs[2] = '{k: 3,  pat: 0, gap_slice: 1, gap_len: 3, exp_done: 16,
                exp_c00: 38, exp_c33: 137, exp_c02: 50};
    vecs[3] = '{k: 3,  pat: 0, gap_slice: 0, gap_len: 0, exp_done: 13,
                exp_c00: 38, exp_c33: 137, exp_c02: 50};
    vecs[4] = '{k: 0,  pat: 0, gap_slice: 0, gap_len: 0, exp_done: 10,
                exp_c00: 0, exp_c33: 0, exp_c02: 0};
    vecs[5] = '{k: 4,  pat: 0, gap_slice: 2, gap_len: 5, exp_done: 19,
                exp_c00: 70, exp_c33: 214, exp_c02: 90};
    vecs[6] = '{k: 12, pat: 1, gap_slice: 0, gap_len: 0, exp_done: 18,
                exp_c00: 520200, exp_c33: 520200, exp_c02: 520200};

    #2;
    check_zero("reset");
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Reset in the middle of FEED leaves stale ACC for the next CLEAR to wipe.
    fill(1);
    run_job("abort", 8, 8, d);

    for (int v = 0; v < 7; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      fill(vecs[v].pat);
      gap[vecs[v].gap_slice] = vecs[v].gap_len;
      run_job(tag, vecs[v].k, -1, d);
      chk({tag, "_tbl_done"}, d, vecs[v].exp_done);
      chk({tag, "_tbl_c00"}, acc[0][0], vecs[v].exp_c00);
      chk({tag, "_tbl_c33"}, acc[3][3], vecs[v].exp_c33);
      chk({tag, "_tbl_c02"}, acc[0][2], vecs[v].exp_c02);
      if (v == 2) begin
        chk("stall_en_c3", longint'(en_hist[3]), 1);
        chk("stall_en_c4", longint'(en_hist[4]), 0);
        chk("stall_en_c5", longint'(en_hist[5]), 0);
        chk("stall_en_c6", longint'(en_hist[6]), 0);
        chk("stall_en_c7", longint'(en_hist[7]), 1);
      end
    end

    for (int r = 0; r < 12; r++) begin
      fill(2);
      for (int s = 0; s < NS; s++) gap[s] = int'($urandom_range(0, 2));
      run_job($sformatf("rnd%0d", r), int'($urandom_range(0, 10)), -1, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
